// File: rtl/sme_loader.sv
// Input capture stage for the string-matching engine: assembles string/pattern buffers,
// pre-decodes the pattern and offers one job per pattern. Optional anchors: SME_LDR_ANCHOR_EN.
module sme_loader #(
    parameter int STR_MAX = 32,
    parameter int PAT_MAX = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [7:0]             chardata,
    input  logic                   isstring,
    input  logic                   ispattern,
    output logic                   in_busy,
    output logic                   job_valid,
    input  logic                   job_ready,
    output logic [8*STR_MAX-1:0]   str_flat,
    output logic [$clog2(STR_MAX+1)-1:0] slen,
    output logic [8*PAT_MAX-1:0]   pat_flat,
    output logic [$clog2(PAT_MAX+1)-1:0] plen,
    output logic [PAT_MAX-1:0]     pat_vmask,
    output logic [PAT_MAX-1:0]     pat_dmask,
    output logic                   star_flag,
    output logic [$clog2(PAT_MAX)-1:0] star_idx,
    output logic                   anchor_head,
    output logic                   anchor_tail,
    output logic                   err_ovf
);

    localparam int SW  = $clog2(STR_MAX + 1);
    localparam int SIW = $clog2(STR_MAX);
    localparam int PW  = $clog2(PAT_MAX + 1);
    localparam int IW  = $clog2(PAT_MAX);

    typedef enum logic [1:0] {IDLE, LOAD_STR, LOAD_PAT, HOLD} state_t;
    state_t state;

    logic                 pat_start;
    logic                 pat_load;
    logic                 pat_drop;
    logic                 do_store;
    logic [IW-1:0]        pidx;
    logic [8*PAT_MAX-1:0] n_flat;
    logic [PW-1:0]        n_plen;
    logic [PAT_MAX-1:0]   n_vmask;
    logic [PAT_MAX-1:0]   n_dmask;
    logic                 n_star_flag;
    logic [IW-1:0]        n_star_idx;

    assign pat_start = ispattern && !isstring && (state == IDLE || state == LOAD_STR);
    assign pat_load  = pat_start || (state == LOAD_PAT && ispattern);

`ifdef SME_LDR_ANCHOR_EN
    logic n_ahead;
    logic n_atail;
    logic n_pend;
    logic tail_pend;
`endif

    // Next pattern buffer/decode state for the byte on chardata; a new pattern starts from zero
    always_comb begin
        n_flat      = pat_start ? '0 : pat_flat;
        n_plen      = pat_start ? '0 : plen;
        n_vmask     = pat_start ? '0 : pat_vmask;
        n_dmask     = pat_start ? '0 : pat_dmask;
        n_star_flag = pat_start ? 1'b0 : star_flag;
        n_star_idx  = pat_start ? '0 : star_idx;
        pat_drop    = 1'b0;
        do_store    = 1'b1;
        pidx        = n_plen[IW-1:0];
`ifdef SME_LDR_ANCHOR_EN
        n_ahead = pat_start ? 1'b0 : anchor_head;
        n_atail = pat_start ? 1'b0 : anchor_tail;
        n_pend  = pat_start ? 1'b0 : tail_pend;
        // A held-back '$' followed by another byte turns out to be a literal
        if (n_pend) begin
            n_flat[{pidx, 3'b000} +: 8] = 8'h24;
            n_vmask[pidx] = 1'b1;
            n_plen  = n_plen + PW'(1);
            n_pend  = 1'b0;
            n_atail = 1'b0;
            pidx    = n_plen[IW-1:0];
        end
        if (pat_start && chardata == 8'h5E) begin
            n_ahead  = 1'b1;
            do_store = 1'b0;
        end else if (chardata == 8'h24 && n_plen < PW'(PAT_MAX)) begin
            n_pend   = 1'b1;
            n_atail  = 1'b1;
            do_store = 1'b0;
        end
`endif
        if (do_store) begin
            if (n_plen == PW'(PAT_MAX)) begin
                pat_drop = 1'b1;
            end else begin
                n_flat[{pidx, 3'b000} +: 8] = chardata;
                n_vmask[pidx] = 1'b1;
                n_dmask[pidx] = (chardata == 8'h2E);
                if (chardata == 8'h2A && !n_star_flag) begin
                    n_star_flag = 1'b1;
                    n_star_idx  = pidx;
                end
                n_plen = n_plen + PW'(1);
            end
        end
    end

    // Control FSM plus all registered buffers and job outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            in_busy   <= 1'b0;
            job_valid <= 1'b0;
            str_flat  <= '0;
            slen      <= '0;
            pat_flat  <= '0;
            plen      <= '0;
            pat_vmask <= '0;
            pat_dmask <= '0;
            star_flag <= 1'b0;
            star_idx  <= '0;
            err_ovf   <= 1'b0;
`ifdef SME_LDR_ANCHOR_EN
            anchor_head <= 1'b0;
            anchor_tail <= 1'b0;
            tail_pend   <= 1'b0;
`endif
        end else begin
            if (pat_load) begin
                pat_flat  <= n_flat;
                plen      <= n_plen;
                pat_vmask <= n_vmask;
                pat_dmask <= n_dmask;
                star_flag <= n_star_flag;
                star_idx  <= n_star_idx;
`ifdef SME_LDR_ANCHOR_EN
                anchor_head <= n_ahead;
                anchor_tail <= n_atail;
                tail_pend   <= n_pend;
`endif
                if (pat_drop) err_ovf <= 1'b1;
            end
            case (state)
                IDLE: begin
                    if (isstring) begin
                        str_flat <= {{(8*STR_MAX-8){1'b0}}, chardata};
                        slen     <= SW'(1);
                        state    <= LOAD_STR;
                    end else if (ispattern) begin
                        state <= LOAD_PAT;
                    end
                end
                LOAD_STR: begin
                    if (isstring) begin
                        if (slen == SW'(STR_MAX)) begin
                            err_ovf <= 1'b1;
                        end else begin
                            str_flat[{slen[SIW-1:0], 3'b000} +: 8] <= chardata;
                            slen <= slen + SW'(1);
                        end
                    end else if (ispattern) begin
                        state <= LOAD_PAT;
                    end else begin
                        state <= IDLE;
                    end
                end
                LOAD_PAT: begin
                    if (!ispattern) begin
                        state     <= HOLD;
                        job_valid <= 1'b1;
                        in_busy   <= 1'b1;
                        if (isstring) err_ovf <= 1'b1;
                    end
                end
                HOLD: begin
                    if (isstring || ispattern) err_ovf <= 1'b1;
                    if (job_ready) begin
                        state     <= IDLE;
                        job_valid <= 1'b0;
                        in_busy   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifndef SME_LDR_ANCHOR_EN
    assign anchor_head = 1'b0;
    assign anchor_tail = 1'b0;
`endif

endmodule

// File: tb/tb_sme_loader.sv
// Scoreboard testbench for sme_loader: expected jobs are modelled from the driven
// strings/patterns, queued, and compared when job_valid appears. Honours SME_LDR_ANCHOR_EN.
module tb_sme_loader;

    typedef struct packed {
        logic [255:0] str;
        logic [5:0]   slen;
        logic [63:0]  pat;
        logic [3:0]   plen;
        logic [7:0]   vm;
        logic [7:0]   dm;
        logic         sf;
        logic [2:0]   si;
        logic         ah;
        logic         at;
    } job_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   chardata = '0;
    logic         isstring = 1'b0;
    logic         ispattern = 1'b0;
    logic         job_ready = 1'b0;
    logic         in_busy, job_valid, star_flag, anchor_head, anchor_tail, err_ovf;
    logic [255:0] str_flat;
    logic [5:0]   slen;
    logic [63:0]  pat_flat;
    logic [3:0]   plen;
    logic [7:0]   pat_vmask, pat_dmask;
    logic [2:0]   star_idx;

    int     n_cmp = 0;
    int     n_bad = 0;
    job_t   expq[$];
    job_t   exp_job, obs_job;
    logic [255:0] cur_str = '0;
    logic [5:0]   cur_slen = '0;

    sme_loader dut (
        .clk(clk), .reset(reset), .chardata(chardata), .isstring(isstring),
        .ispattern(ispattern), .in_busy(in_busy), .job_valid(job_valid),
        .job_ready(job_ready), .str_flat(str_flat), .slen(slen), .pat_flat(pat_flat),
        .plen(plen), .pat_vmask(pat_vmask), .pat_dmask(pat_dmask), .star_flag(star_flag),
        .star_idx(star_idx), .anchor_head(anchor_head), .anchor_tail(anchor_tail),
        .err_ovf(err_ovf)
    );

    always #5 clk = ~clk;

    function automatic job_t observe();
        job_t j;
        j.str = str_flat;   j.slen = slen;      j.pat = pat_flat;   j.plen = plen;
        j.vm = pat_vmask;   j.dm = pat_dmask;   j.sf = star_flag;   j.si = star_idx;
        j.ah = anchor_head; j.at = anchor_tail;
        return j;
    endfunction

    // Reference: strip anchors (if enabled), truncate to 8 bytes, decode masks and first '*'
    function automatic job_t make_job(input string p);
        job_t j;
        int   first;
        int   last;
        logic [7:0] c;
        j = '0;
        j.str = cur_str;
        j.slen = cur_slen;
        first = 0;
        last = p.len();
`ifdef SME_LDR_ANCHOR_EN
        c = p[0];
        if (last > 0 && c == 8'h5E) begin
            j.ah = 1'b1;
            first = 1;
        end
        c = p[last-1];
        if (last > first && c == 8'h24) begin
            j.at = 1'b1;
            last = last - 1;
        end
`endif
        for (int i = first; i < last; i++) begin
            c = p[i];
            if (j.plen < 4'd8) begin
                j.pat[8*j.plen +: 8] = c;
                j.vm[j.plen[2:0]] = 1'b1;
                j.dm[j.plen[2:0]] = (c == 8'h2E);
                if (c == 8'h2A && !j.sf) begin
                    j.sf = 1'b1;
                    j.si = j.plen[2:0];
                end
                j.plen = j.plen + 4'd1;
            end
        end
        return j;
    endfunction

    task automatic drive_string(input string s);
        cur_str = '0;
        for (int i = 0; i < s.len(); i++) begin
            @(negedge clk);
            isstring = 1'b1;
            chardata = s[i];
            if (i < 32) cur_str[8*i +: 8] = s[i];
        end
        cur_slen = (s.len() > 32) ? 6'd32 : 6'(s.len());
        @(negedge clk);
        isstring = 1'b0;
        chardata = '0;
    endtask

    task automatic drive_pattern(input string p);
        expq.push_back(make_job(p));
        for (int i = 0; i < p.len(); i++) begin
            @(negedge clk);
            ispattern = 1'b1;
            chardata = p[i];
        end
        @(negedge clk);
        ispattern = 1'b0;
        chardata = '0;
    endtask

    task automatic pulse_ready();
        @(negedge clk);
        job_ready = 1'b1;
        @(negedge clk);
        job_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        @(negedge clk);
        obs_job = observe();
        n_cmp++;
        if (obs_job !== '0) begin
            $display("[TB] FAIL reset_fields: got %h want 0", obs_job); n_bad++;
        end
        n_cmp++;
        if ({job_valid, in_busy, err_ovf} !== 3'b000) begin
            $display("[TB] FAIL reset_ctrl: got %b want 000", {job_valid, in_busy, err_ovf}); n_bad++;
        end
        reset = 1'b1;
    endtask

    task automatic test_basic();
        job_ready = 1'b1;
        drive_string("ABCDE");
        drive_pattern("B.D");
        @(negedge clk);
        n_cmp++;
        if ({job_valid, in_busy} !== 2'b11) begin
            $display("[TB] FAIL basic_latency: valid/busy=%b want 11", {job_valid, in_busy}); n_bad++;
        end
        exp_job = expq.pop_front();
        obs_job = observe();
        n_cmp++;
        if (obs_job !== exp_job) begin
            $display("[TB] FAIL basic_job: got %h want %h", obs_job, exp_job); n_bad++;
        end
        n_cmp++;
        if ({slen, plen, pat_vmask, pat_dmask, star_flag, err_ovf} !== {6'd5, 4'd3, 8'h07, 8'h02, 1'b0, 1'b0}) begin
            $display("[TB] FAIL basic_decode: slen=%0d plen=%0d vm=%h dm=%h sf=%b ovf=%b",
                     slen, plen, pat_vmask, pat_dmask, star_flag, err_ovf); n_bad++;
        end
        @(negedge clk);
        n_cmp++;
        if ({job_valid, in_busy} !== 2'b00) begin
            $display("[TB] FAIL basic_accept: valid/busy=%b want 00", {job_valid, in_busy}); n_bad++;
        end
        job_ready = 1'b0;
    endtask

    task automatic test_hold_stall();
        drive_pattern("A*C");
        @(negedge clk);
        exp_job = expq.pop_front();
        for (int i = 0; i < 10; i++) begin
            isstring = (i == 3);
            chardata = (i == 3) ? 8'h58 : 8'h00;
            obs_job = observe();
            n_cmp++;
            if (obs_job !== exp_job || job_valid !== 1'b1 || in_busy !== 1'b1) begin
                $display("[TB] FAIL hold_stable[%0d]: got %h v=%b b=%b want %h v=1 b=1",
                         i, obs_job, job_valid, in_busy, exp_job); n_bad++;
            end
            @(negedge clk);
        end
        isstring = 1'b0;
        chardata = '0;
        n_cmp++;
        if ({err_ovf, star_flag, star_idx} !== {1'b1, 1'b1, 3'd1}) begin
            $display("[TB] FAIL hold_ovf_star: ovf=%b sf=%b si=%0d want 1 1 1", err_ovf, star_flag, star_idx); n_bad++;
        end
        pulse_ready();
        n_cmp++;
        if ({job_valid, in_busy} !== 2'b00) begin
            $display("[TB] FAIL hold_release: valid/busy=%b want 00", {job_valid, in_busy}); n_bad++;
        end
    endtask

    task automatic test_overflow();
        string s;
        @(negedge clk);
        reset = 1'b0;
        cur_str = '0;
        cur_slen = '0;
        @(negedge clk);
        reset = 1'b1;
        s = "";
        for (int i = 0; i < 34; i++) s = $sformatf("%s%c", s, 8'h61 + i % 26);
        drive_string(s);
        n_cmp++;
        if ({slen, err_ovf} !== {6'd32, 1'b1}) begin
            $display("[TB] FAIL ovf_string: slen=%0d ovf=%b want 32 1", slen, err_ovf); n_bad++;
        end
        drive_pattern("abcdefghij");
        @(negedge clk);
        exp_job = expq.pop_front();
        obs_job = observe();
        n_cmp++;
        if (obs_job !== exp_job || plen !== 4'd8 || job_valid !== 1'b1) begin
            $display("[TB] FAIL ovf_pattern: got %h plen=%0d v=%b want %h plen=8 v=1",
                     obs_job, plen, job_valid, exp_job); n_bad++;
        end
        pulse_ready();
    endtask

    task automatic test_back_to_back();
        drive_string("HELLOWORLD");
        drive_pattern("L*O");
        @(negedge clk);
        exp_job = expq.pop_front();
        obs_job = observe();
        n_cmp++;
        if (obs_job !== exp_job || job_valid !== 1'b1) begin
            $display("[TB] FAIL b2b_first: got %h v=%b want %h", obs_job, job_valid, exp_job); n_bad++;
        end
        pulse_ready();
        drive_pattern("W.R");
        @(negedge clk);
        exp_job = expq.pop_front();
        obs_job = observe();
        n_cmp++;
        if (obs_job !== exp_job || job_valid !== 1'b1) begin
            $display("[TB] FAIL b2b_second: got %h v=%b want %h", obs_job, job_valid, exp_job); n_bad++;
        end
        n_cmp++;
        if ({slen, star_flag, pat_dmask} !== {6'd10, 1'b0, 8'h02}) begin
            $display("[TB] FAIL b2b_fields: slen=%0d sf=%b dm=%h want 10 0 02", slen, star_flag, pat_dmask); n_bad++;
        end
        pulse_ready();
    endtask

    task automatic test_anchor();
        drive_pattern("^AB$");
        @(negedge clk);
        exp_job = expq.pop_front();
        obs_job = observe();
        n_cmp++;
        if (obs_job !== exp_job) begin
            $display("[TB] FAIL anchor_job: got %h want %h", obs_job, exp_job); n_bad++;
        end
        n_cmp++;
`ifdef SME_LDR_ANCHOR_EN
        if ({plen, anchor_head, anchor_tail, pat_flat[15:0]} !== {4'd2, 1'b1, 1'b1, 16'h4241}) begin
            $display("[TB] FAIL anchor_on: plen=%0d ah=%b at=%b lo=%h want 2 1 1 4241",
                     plen, anchor_head, anchor_tail, pat_flat[15:0]); n_bad++;
        end
`else
        if ({plen, anchor_head, anchor_tail, pat_flat[31:0]} !== {4'd4, 1'b0, 1'b0, 32'h2442415E}) begin
            $display("[TB] FAIL anchor_off: plen=%0d ah=%b at=%b lo=%h want 4 0 0 2442415e",
                     plen, anchor_head, anchor_tail, pat_flat[31:0]); n_bad++;
        end
`endif
        pulse_ready();
        drive_pattern("A$B");
        @(negedge clk);
        exp_job = expq.pop_front();
        obs_job = observe();
        n_cmp++;
        if (obs_job !== exp_job || plen !== 4'd3 || anchor_tail !== 1'b0) begin
            $display("[TB] FAIL anchor_literal: got %h want %h", obs_job, exp_job); n_bad++;
        end
        pulse_ready();
    endtask

    task automatic test_reset_mid_load();
        drive_string("QRS");
        @(negedge clk);
        ispattern = 1'b1;
        chardata = 8'h4D;
        @(negedge clk);
        chardata = 8'h4E;
        @(negedge clk);
        reset = 1'b0;
        ispattern = 1'b0;
        chardata = '0;
        cur_str = '0;
        cur_slen = '0;
        #1;
        obs_job = observe();
        n_cmp++;
        if (obs_job !== '0 || {job_valid, in_busy, err_ovf} !== 3'b000) begin
            $display("[TB] FAIL midreset_clear: got %h ctrl=%b want 0 000",
                     obs_job, {job_valid, in_busy, err_ovf}); n_bad++;
        end
        @(negedge clk);
        reset = 1'b1;
        drive_string("OK");
        drive_pattern("K");
        @(negedge clk);
        exp_job = expq.pop_front();
        obs_job = observe();
        n_cmp++;
        if (obs_job !== exp_job || job_valid !== 1'b1 || err_ovf !== 1'b0) begin
            $display("[TB] FAIL midreset_reload: got %h v=%b ovf=%b want %h v=1 ovf=0",
                     obs_job, job_valid, err_ovf, exp_job); n_bad++;
        end
        pulse_ready();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold_stall();
        test_overflow();
        test_back_to_back();
        test_anchor();
        test_reset_mid_load();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
